auth_host_initiator: RTL and testbench

Host-side initiator for the wake/READY/CRC-framed UID authentication protocol served by the FPGA auth responder. It accepts one request (command plus up to 16 UID bytes), pulls the wake line low, and waits for the READY byte. It then transmits the frame and returns the single result byte, or a timeout status. It sits between a host controller and the shared byte-level uart_tx/uart_rx instances, and drives the responder's `fpga_wake` input.

---
 rtl/auth_host_initiator.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_auth_host_initiator.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auth_host_initiator.sv
// auth_host_initiator: host-side initiator for the wake/READY/CRC-framed UID
// authentication protocol. Takes one request, pulls fpga_wake low, waits for
// READY, sends MAGIC/CMD/LEN/PAYLOAD/CRC, and reports the result byte or a
// timeout status. Optional feature macro: AUTH_INIT_RETRY_EN (one automatic
// retry after a missing READY byte).
module auth_host_initiator #(
  parameter int unsigned CLK_HZ           = 27000000,
  parameter int unsigned READY_TIMEOUT_MS = 10,
  parameter int unsigned RESP_TIMEOUT_MS  = 50,
  parameter int unsigned WAKE_GUARD_CYC   = 16,
  parameter logic [7:0]  MAGIC_BYTE       = 8'hA5,
  parameter logic [7:0]  READY_BYTE       = 8'h52,
  parameter logic [7:0]  CRC8_POLY        = 8'h07
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [7:0]   req_cmd,
  input  logic [7:0]   req_len,
  input  logic [127:0] req_uid_flat,
  output logic         resp_valid,
  output logic [7:0]   resp_byte,
  output logic [1:0]   resp_status,
  output logic         fpga_wake,
  output logic         tx_dv,
  output logic [7:0]   tx_byte,
  input  logic         tx_busy,
  input  logic         tx_done,
  input  logic         rx_dv,
  input  logic [7:0]   rx_byte
);

  localparam int unsigned MS_CYCLES   = CLK_HZ / 1000;
  localparam logic [31:0] READY_TO_CYC = 32'(READY_TIMEOUT_MS * MS_CYCLES);
  localparam logic [31:0] RESP_TO_CYC  = 32'(RESP_TIMEOUT_MS * MS_CYCLES);
  localparam logic [31:0] GUARD_LAST   = (WAKE_GUARD_CYC > 0) ? 32'(WAKE_GUARD_CYC - 1) : 32'd0;

  localparam logic [1:0] STAT_OK       = 2'b00;
  localparam logic [1:0] STAT_NO_READY = 2'b01;
  localparam logic [1:0] STAT_NO_RESP  = 2'b10;
  localparam logic [1:0] STAT_BAD_LEN  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_WAKE, S_WAIT_READY, S_TX_MAGIC, S_TX_CMD, S_TX_LEN,
    S_TX_PAYLOAD, S_TX_CRC, S_WAIT_RESULT, S_RELEASE
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [7:0]     len_q, len_d;
  logic [127:0]   uid_q, uid_d;
  logic [4:0]     idx_q, idx_d;
  logic [7:0]     crc_q, crc_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           sent_q, sent_d;
  logic           wake_q, wake_d;
  logic           tx_dv_q, tx_dv_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           resp_valid_q, resp_valid_d;
  logic [7:0]     resp_byte_q, resp_byte_d;
  logic [1:0]     resp_status_q, resp_status_d;
`ifdef AUTH_INIT_RETRY_EN
  logic           retry_used_q, retry_used_d;
  logic           again_q, again_d;
`endif

  logic [31:0]    cnt_inc;
  logic           tx_state;
  logic           crc_en;
  logic [7:0]     tx_cur;
  state_t         tx_next;
  logic [7:0]     payload_byte;

  // One CRC-8 step over a whole byte: MSB-first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = {c[6:0], 1'b0} ^ (c[7] ? CRC8_POLY : 8'h00);
    end
    return c;
  endfunction

  assign payload_byte = uid_q[{idx_q[3:0], 3'b000} +: 8];
  assign cnt_inc      = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  // Next-state and next-output logic for the whole transaction sequencer.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    uid_d         = uid_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    cnt_d         = cnt_q;
    sent_d        = sent_q;
    wake_d        = wake_q;
    tx_dv_d       = 1'b0;
    tx_byte_d     = tx_byte_q;
    resp_valid_d  = 1'b0;
    resp_byte_d   = resp_byte_q;
    resp_status_d = resp_status_q;
`ifdef AUTH_INIT_RETRY_EN
    retry_used_d  = retry_used_q;
    again_d       = again_q;
`endif
    tx_state      = 1'b0;
    crc_en        = 1'b0;
    tx_cur        = 8'h00;
    tx_next       = state_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_len > 8'd16) begin
            resp_valid_d  = 1'b1;
            resp_status_d = STAT_BAD_LEN;
            resp_byte_d   = 8'h00;
          end else begin
            cmd_d   = req_cmd;
            len_d   = req_len;
            uid_d   = req_uid_flat;
            state_d = S_WAKE;
`ifdef AUTH_INIT_RETRY_EN
            retry_used_d = 1'b0;
            again_d      = 1'b0;
`endif
          end
        end
      end
      S_WAKE: begin
        wake_d  = 1'b0;
        cnt_d   = 32'd0;
        crc_d   = 8'h00;
        idx_d   = 5'd0;
        sent_d  = 1'b0;
        state_d = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (rx_dv && (rx_byte == READY_BYTE)) begin
          state_d = S_TX_MAGIC;
        end else if (cnt_inc >= READY_TO_CYC) begin
`ifdef AUTH_INIT_RETRY_EN
          if (!retry_used_q) begin
            retry_used_d = 1'b1;
            again_d      = 1'b1;
            wake_d       = 1'b1;
            cnt_d        = 32'd0;
            state_d      = S_RELEASE;
          end else begin
            wake_d        = 1'b1;
            resp_valid_d  = 1'b1;
            resp_status_d = STAT_NO_READY;
            resp_byte_d   = 8'h00;
            cnt_d         = 32'd0;
            state_d       = S_RELEASE;
          end
`else
          wake_d        = 1'b1;
          resp_valid_d  = 1'b1;
          resp_status_d = STAT_NO_READY;
          resp_byte_d   = 8'h00;
          cnt_d         = 32'd0;
          state_d       = S_RELEASE;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_TX_MAGIC: begin
        tx_state = 1'b1;
        tx_cur   = MAGIC_BYTE;
        tx_next  = S_TX_CMD;
      end
      S_TX_CMD: begin
        tx_state = 1'b1;
        crc_en   = 1'b1;
        tx_cur   = cmd_q;
        tx_next  = S_TX_LEN;
      end
      S_TX_LEN: begin
        tx_state = 1'b1;
        crc_en   = 1'b1;
        tx_cur   = len_q;
        tx_next  = (len_q == 8'd0) ? S_TX_CRC : S_TX_PAYLOAD;
      end
      S_TX_PAYLOAD: begin
        tx_state = 1'b1;
        crc_en   = 1'b1;
        tx_cur   = payload_byte;
        tx_next  = (({3'b000, idx_q} + 8'd1) == len_q) ? S_TX_CRC : S_TX_PAYLOAD;
      end
      S_TX_CRC: begin
        tx_state = 1'b1;
        tx_cur   = crc_q;
        tx_next  = S_WAIT_RESULT;
      end
      S_WAIT_RESULT: begin
        if (rx_dv) begin
          wake_d        = 1'b1;
          resp_valid_d  = 1'b1;
          resp_status_d = STAT_OK;
          resp_byte_d   = rx_byte;
          cnt_d         = 32'd0;
          state_d       = S_RELEASE;
        end else if (cnt_inc >= RESP_TO_CYC) begin
          wake_d        = 1'b1;
          resp_valid_d  = 1'b1;
          resp_status_d = STAT_NO_RESP;
          resp_byte_d   = 8'h00;
          cnt_d         = 32'd0;
          state_d       = S_RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RELEASE: begin
        wake_d = 1'b1;
        if (cnt_q >= GUARD_LAST) begin
          cnt_d = 32'd0;
`ifdef AUTH_INIT_RETRY_EN
          if (again_q) begin
            again_d = 1'b0;
            state_d = S_WAKE;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared byte-send handshake: strobe once when uart_tx is idle, then wait for done.
    if (tx_state) begin
      if (!sent_q) begin
        if (!tx_busy) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = tx_cur;
          sent_d    = 1'b1;
          if (crc_en) begin
            crc_d = crc8_step(crc_q, tx_cur);
          end
        end
      end else if (tx_done) begin
        sent_d  = 1'b0;
        state_d = tx_next;
        if (state_q == S_TX_PAYLOAD) begin
          idx_d = idx_q + 5'd1;
        end
        if (state_q == S_TX_CRC) begin
          cnt_d = 32'd0;
        end
      end
    end
  end

  // State and registered outputs; reset aborts everything and releases wake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cmd_q         <= 8'h00;
      len_q         <= 8'h00;
      uid_q         <= '0;
      idx_q         <= 5'd0;
      crc_q         <= 8'h00;
      cnt_q         <= 32'd0;
      sent_q        <= 1'b0;
      wake_q        <= 1'b1;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= 8'h00;
      resp_valid_q  <= 1'b0;
      resp_byte_q   <= 8'h00;
      resp_status_q <= 2'b00;
`ifdef AUTH_INIT_RETRY_EN
      retry_used_q  <= 1'b0;
      again_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      uid_q         <= uid_d;
      idx_q         <= idx_d;
      crc_q         <= crc_d;
      cnt_q         <= cnt_d;
      sent_q        <= sent_d;
      wake_q        <= wake_d;
      tx_dv_q       <= tx_dv_d;
      tx_byte_q     <= tx_byte_d;
      resp_valid_q  <= resp_valid_d;
      resp_byte_q   <= resp_byte_d;
      resp_status_q <= resp_status_d;
`ifdef AUTH_INIT_RETRY_EN
      retry_used_q  <= retry_used_d;
      again_q       <= again_d;
`endif
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign fpga_wake   = wake_q;
  assign tx_dv       = tx_dv_q;
  assign tx_byte     = tx_byte_q;
  assign resp_valid  = resp_valid_q;
  assign resp_byte   = resp_byte_q;
  assign resp_status = resp_status_q;

endmodule

// File: tb/tb_auth_host_initiator.sv
// Testbench for auth_host_initiator: a uart_tx model plus scoreboards for
// transmitted bytes and result pulses. Honours AUTH_INIT_RETRY_EN if defined.
module tb_auth_host_initiator;

  localparam int READY_CYC = 40;   // 10 ms at 4 cycles per ms
  localparam int RESP_CYC  = 200;  // 50 ms at 4 cycles per ms
  localparam int GUARD     = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [7:0]   req_cmd = 8'h00;
  logic [7:0]   req_len = 8'h00;
  logic [127:0] req_uid_flat = '0;
  logic         resp_valid;
  logic [7:0]   resp_byte;
  logic [1:0]   resp_status;
  logic         fpga_wake;
  logic         tx_dv;
  logic [7:0]   tx_byte;
  logic         tx_busy = 1'b0;
  logic         tx_done = 1'b0;
  logic         rx_dv = 1'b0;
  logic [7:0]   rx_byte = 8'h00;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cycle = 0;
  int resp_cycle = 0;
  int tx_strobes = 0;
  int resp_cnt = 0;
  int busy_cnt = 0;
  bit prev_dv = 1'b0;
  bit prev_wake = 1'b1;
  int wake_low_cnt = 0;
  int wake_falls = 0;
  int high_run = 0;
  int min_gap = 1000000;

  logic [7:0] exp_tx[$];
  logic [9:0] exp_resp[$];

  auth_host_initiator #(.CLK_HZ(4000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_len(req_len), .req_uid_flat(req_uid_flat),
    .resp_valid(resp_valid), .resp_byte(resp_byte), .resp_status(resp_status),
    .fpga_wake(fpga_wake),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_dv(rx_dv), .rx_byte(rx_byte)
  );

  always #5 clk = ~clk;

  // Bit-serial reference CRC-8 (poly 0x07, init 0, MSB-first).
  function automatic logic [7:0] ref_crc_byte(input logic [7:0] crc, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb  = crc[7] ^ d[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return crc;
  endfunction

  task automatic push_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [127:0] uid);
    logic [7:0] c;
    logic [7:0] b;
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(cmd);
    exp_tx.push_back(len);
    c = ref_crc_byte(8'h00, cmd);
    c = ref_crc_byte(c, len);
    for (int i = 0; i < int'(len); i++) begin
      b = uid[8*i +: 8];
      exp_tx.push_back(b);
      c = ref_crc_byte(c, b);
    end
    exp_tx.push_back(c);
  endtask

  // uart_tx model, tx byte scoreboard, result scoreboard and wake-window tracking.
  always @(negedge clk) begin
    logic [7:0] et;
    logic [9:0] er;
    cyc++;
    if (!rst_n) begin
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
      busy_cnt = 0;
      prev_dv  = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (tx_dv) begin
        n_vec++;
        if (tx_busy || prev_dv) begin
          n_fail++;
          $display("[TB] FAIL tx_dv_protocol: busy=%0b prev_dv=%0b, required both 0", tx_busy, prev_dv);
        end
        n_vec++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL tx_unexpected: got byte %h, required no strobe", tx_byte);
        end else begin
          et = exp_tx.pop_front();
          if (tx_byte !== et) begin
            n_fail++;
            $display("[TB] FAIL tx_byte: got %h, required %h", tx_byte, et);
          end
        end
        tx_strobes++;
        tx_busy  = 1'b1;
        busy_cnt = 2;
      end else if (tx_busy) begin
        if (busy_cnt == 0) begin
          tx_busy    = 1'b0;
          tx_done    = 1'b1;
          done_cycle = cyc;
        end else begin
          busy_cnt--;
        end
      end
      prev_dv = tx_dv;

      if (fpga_wake === 1'b0) begin
        wake_low_cnt++;
        if (prev_wake) begin
          wake_falls++;
          if (wake_falls > 1 && high_run < min_gap) min_gap = high_run;
        end
        high_run = 0;
      end else begin
        high_run++;
      end
      prev_wake = fpga_wake;

      if (resp_valid) begin
        resp_cnt++;
        resp_cycle = cyc;
        n_vec++;
        if (exp_resp.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL resp_unexpected: got status %b byte %h, required no pulse", resp_status, resp_byte);
        end else begin
          er = exp_resp.pop_front();
          if ({resp_status, resp_byte} !== er) begin
            n_fail++;
            $display("[TB] FAIL resp_value: got status %b byte %h, required status %b byte %h",
                     resp_status, resp_byte, er[9:8], er[7:0]);
          end
        end
        n_vec++;
        if (fpga_wake !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL wake_at_resp: got %b, required 1", fpga_wake);
        end
      end
    end
  end

  task automatic do_request(input logic [7:0] cmd, input logic [7:0] len, input logic [127:0] uid);
    @(negedge clk);
    req_valid    = 1'b1;
    req_cmd      = cmd;
    req_len      = len;
    req_uid_flat = uid;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_tx.size() == 0 && !tx_busy && !tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_resp(input int start, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (resp_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({fpga_wake, tx_dv, tx_byte, resp_valid, resp_byte, resp_status} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got wake=%b dv=%b byte=%h rv=%b rb=%h rs=%b, required 1 0 00 0 00 00",
               fpga_wake, tx_dv, tx_byte, resp_valid, resp_byte, resp_status);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_req_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_check_len0();
    int s0, r0;
    bit ok;
    s0 = tx_strobes;
    r0 = resp_cnt;
    push_frame(8'h10, 8'h00, '0);
    exp_resp.push_back({2'b00, 8'h00});
    do_request(8'h10, 8'h00, '0);
    @(negedge clk);
    #1;
    n_vec++;
    if (fpga_wake !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wake_fall_timing: got %b, required 0", fpga_wake);
    end
    repeat (4) @(negedge clk);
    send_rx(8'h52);
    wait_tx_idle(100, ok);
    send_rx(8'h00);
    wait_resp(r0, 50, ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL check_resp_timeout: got no resp_valid, required one");
    end
    n_vec++;
    if (tx_strobes - s0 != 4) begin
      n_fail++;
      $display("[TB] FAIL check_strobe_count: got %0d, required 4", tx_strobes - s0);
    end
    repeat (GUARD + 2) @(negedge clk);
    #1;
    n_vec++;
    if ({fpga_wake, req_ready} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL check_idle_after: got wake=%b ready=%b, required 1 1", fpga_wake, req_ready);
    end
  endtask

  task automatic test_add();
    int s0, r0;
    bit ok;
    logic [127:0] uid;
    uid = '0;
    uid[31:0] = 32'hEFBEADDE;
    s0 = tx_strobes;
    r0 = resp_cnt;
    push_frame(8'h11, 8'h04, uid);
    exp_resp.push_back({2'b00, 8'h02});
    do_request(8'h11, 8'h04, uid);
    repeat (3) @(negedge clk);
    send_rx(8'h52);
    @(negedge clk);
    send_rx(8'h99);
    wait_tx_idle(200, ok);
    send_rx(8'h02);
    wait_resp(r0, 50, ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL add_resp_timeout: got no resp_valid, required one");
    end
    n_vec++;
    if (tx_strobes - s0 != 8) begin
      n_fail++;
      $display("[TB] FAIL add_strobe_count: got %0d, required 8", tx_strobes - s0);
    end
    repeat (8) @(negedge clk);
    #1;
    n_vec++;
    if ({resp_status, resp_byte} !== {2'b00, 8'h02}) begin
      n_fail++;
      $display("[TB] FAIL add_resp_stable: got %b %h, required 00 02", resp_status, resp_byte);
    end
    repeat (GUARD) @(negedge clk);
  endtask

  task automatic test_bad_len();
    int s0, r0, f0;
    bit wake_ok;
    s0 = tx_strobes;
    r0 = resp_cnt;
    f0 = wake_falls;
    exp_resp.push_back({2'b11, 8'h00});
    do_request(8'h10, 8'd17, '0);
    #1;
    n_vec++;
    if (resp_cnt != r0 + 1) begin
      n_fail++;
      $display("[TB] FAIL badlen_pulse: got %0d pulses, required 1", resp_cnt - r0);
    end
    wake_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (fpga_wake !== 1'b1) wake_ok = 1'b0;
    end
    n_vec++;
    if (!wake_ok || wake_falls != f0) begin
      n_fail++;
      $display("[TB] FAIL badlen_wake: got wake low seen, required wake high");
    end
    n_vec++;
    if (tx_strobes != s0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL badlen_idle: got strobes=%0d ready=%b, required 0 1", tx_strobes - s0, req_ready);
    end
  endtask

  task automatic test_no_ready();
    int s0, r0, exp_low, exp_win;
    bit ok;
`ifdef AUTH_INIT_RETRY_EN
    exp_low = 2 * READY_CYC;
    exp_win = 2;
`else
    exp_low = READY_CYC;
    exp_win = 1;
`endif
    @(negedge clk);
    #1;
    wake_low_cnt = 0;
    wake_falls   = 0;
    min_gap      = 1000000;
    s0 = tx_strobes;
    r0 = resp_cnt;
    exp_resp.push_back({2'b01, 8'h00});
    do_request(8'h10, 8'h00, '0);
    wait_resp(r0, 3 * READY_CYC + 100, ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL noready_resp_timeout: got no resp_valid, required one");
    end
    n_vec++;
    if (wake_low_cnt != exp_low || wake_falls != exp_win) begin
      n_fail++;
      $display("[TB] FAIL noready_wake_window: got %0d low cycles in %0d windows, required %0d in %0d",
               wake_low_cnt, wake_falls, exp_low, exp_win);
    end
    n_vec++;
    if (tx_strobes != s0) begin
      n_fail++;
      $display("[TB] FAIL noready_strobes: got %0d, required 0", tx_strobes - s0);
    end
`ifdef AUTH_INIT_RETRY_EN
    n_vec++;
    if (min_gap < GUARD) begin
      n_fail++;
      $display("[TB] FAIL retry_gap: got %0d high cycles, required at least %0d", min_gap, GUARD);
    end
`endif
    repeat (GUARD + 2) @(negedge clk);
  endtask

  task automatic test_no_resp_back_to_back();
    int s0, r0, f0;
    bit ok;
    logic [127:0] uid;
    uid = '0;
    uid[15:0] = 16'h0201;
    s0 = tx_strobes;
    r0 = resp_cnt;
    push_frame(8'h10, 8'h02, uid);
    exp_resp.push_back({2'b10, 8'h00});
    do_request(8'h10, 8'h02, uid);
    repeat (3) @(negedge clk);
    send_rx(8'h33);
    repeat (4) @(negedge clk);
    #1;
    n_vec++;
    if (tx_strobes != s0) begin
      n_fail++;
      $display("[TB] FAIL stray_ignored: got %0d strobes, required 0", tx_strobes - s0);
    end
    send_rx(8'h52);
    wait_tx_idle(200, ok);
    wait_resp(r0, RESP_CYC + 50, ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL noresp_timeout: got no resp_valid, required one");
    end
    n_vec++;
    if (resp_cycle - done_cycle != RESP_CYC + 1) begin
      n_fail++;
      $display("[TB] FAIL noresp_latency: got %0d cycles, required %0d", resp_cycle - done_cycle, RESP_CYC + 1);
    end
    n_vec++;
    if (tx_strobes - s0 != 6) begin
      n_fail++;
      $display("[TB] FAIL noresp_strobes: got %0d, required 6", tx_strobes - s0);
    end
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL release_ready: got %b, required 0", req_ready);
    end
    f0 = wake_falls;
    r0 = resp_cnt;
    s0 = tx_strobes;
    req_valid = 1'b1;
    req_cmd   = 8'h10;
    req_len   = 8'h00;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    repeat (GUARD + 15) @(negedge clk);
    #1;
    n_vec++;
    if (wake_falls != f0 || resp_cnt != r0 || tx_strobes != s0) begin
      n_fail++;
      $display("[TB] FAIL release_req_ignored: got falls=%0d resps=%0d strobes=%0d, required 0 0 0",
               wake_falls - f0, resp_cnt - r0, tx_strobes - s0);
    end
  endtask

  task automatic test_reset_mid_payload();
    int s0, r0;
    bit ok, found;
    logic [127:0] uid;
    for (int i = 0; i < 4; i++) uid[32*i +: 32] = $urandom;
    s0 = tx_strobes;
    push_frame(8'h11, 8'd16, uid);
    do_request(8'h11, 8'd16, uid);
    repeat (3) @(negedge clk);
    send_rx(8'h52);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (tx_dv === 1'b1 && tx_strobes - s0 >= 6) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL midpay_reach: got %0d strobes, required 6", tx_strobes - s0);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({fpga_wake, tx_dv, resp_valid} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL midpay_reset: got wake=%b dv=%b rv=%b, required 1 0 0", fpga_wake, tx_dv, resp_valid);
    end
    exp_tx.delete();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    s0 = tx_strobes;
    r0 = resp_cnt;
    uid = '0;
    uid[7:0] = 8'h7E;
    push_frame(8'h10, 8'h01, uid);
    exp_resp.push_back({2'b00, 8'h01});
    do_request(8'h10, 8'h01, uid);
    repeat (3) @(negedge clk);
    send_rx(8'h52);
    wait_tx_idle(200, ok);
    send_rx(8'h01);
    wait_resp(r0, 50, ok);
    n_vec++;
    if (!ok || tx_strobes - s0 != 5) begin
      n_fail++;
      $display("[TB] FAIL post_reset_txn: got resp=%0b strobes=%0d, required 1 5", ok, tx_strobes - s0);
    end
    repeat (GUARD + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_check_len0();
    test_add();
    test_bad_len();
    test_no_ready();
    test_no_resp_back_to_back();
    test_reset_mid_payload();
    n_vec++;
    if (exp_tx.size() != 0 || exp_resp.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL leftover_expected: got %0d tx and %0d resp pending, required 0 0",
               exp_tx.size(), exp_resp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
